// File: rtl/led_pwm_bank.sv
// LED output bank: per-channel OFF/ON/PWM/BLINK modes with period-aligned duty shadows,
// a shared blink timebase, registered readback and a selectable pin polarity.
module led_pwm_bank #(
    parameter int  NUM_LEDS   = 8,
    parameter int  PWM_BITS   = 8,
    parameter int  PRESC_BITS = 22,
    parameter bit  ACTIVE_LOW = 1'b0,
    localparam int AW         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
    localparam int DW         = PWM_BITS + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [DW-1:0]       rd_data,
    output logic [NUM_LEDS-1:0] led
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_PWM   = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    mode_e               mode_q    [NUM_LEDS];
    mode_e               mode_d    [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_q    [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_d    [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_sh_q [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_sh_d [NUM_LEDS];

    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [PRESC_BITS-1:0] presc_q, presc_d;
    logic                  blink_ph_q, blink_ph_d;
    logic [DW-1:0]         rd_data_q, rd_data_d;
    logic [NUM_LEDS-1:0]   led_q, led_d;
    logic [NUM_LEDS-1:0]   lit;
    logic                  pwm_wrap;

    assign pwm_wrap = &pwm_cnt_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        presc_d    = presc_q + 1'b1;
        blink_ph_d = blink_ph_q ^ (&presc_q);
        rd_data_d  = '0;
        lit        = '0;
        led_d      = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            mode_d[i] = mode_q[i];
            duty_d[i] = duty_q[i];
            // The shadow samples the pre-write duty, so a write on the wrap edge lands one period later.
            duty_sh_d[i] = pwm_wrap ? duty_q[i] : duty_sh_q[i];

            if (wr_en && (wr_addr == AW'(i))) begin
                mode_d[i] = mode_e'(wr_data[DW-1 -: 2]);
                duty_d[i] = wr_data[PWM_BITS-1:0];
            end

            if (rd_addr == AW'(i)) begin
                rd_data_d = {mode_q[i], duty_q[i]};
            end

            case (mode_q[i])
                MODE_OFF:   lit[i] = 1'b0;
                MODE_ON:    lit[i] = 1'b1;
                MODE_PWM:   lit[i] = (pwm_cnt_q < duty_sh_q[i]);
                MODE_BLINK: lit[i] = blink_ph_q && (pwm_cnt_q < duty_sh_q[i]);
                default:    lit[i] = 1'b0;
            endcase
            led_d[i] = lit[i] ^ ACTIVE_LOW;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the per-channel arrays are reset too; a stale mode would drive the pins straight out of reset.
        if (rst) begin
            mode_q     <= '{default: MODE_OFF};
            duty_q     <= '{default: '0};
            duty_sh_q  <= '{default: '0};
            pwm_cnt_q  <= '0;
            presc_q    <= '0;
            blink_ph_q <= 1'b0;
            rd_data_q  <= '0;
            led_q      <= {NUM_LEDS{ACTIVE_LOW}};
        end else begin
            // NOTE: non-blocking only, so every flop samples the values from before this edge.
            mode_q     <= mode_d;
            duty_q     <= duty_d;
            duty_sh_q  <= duty_sh_d;
            pwm_cnt_q  <= pwm_cnt_d;
            presc_q    <= presc_d;
            blink_ph_q <= blink_ph_d;
            rd_data_q  <= rd_data_d;
            led_q      <= led_d;
        end
    end

    assign rd_data = rd_data_q;
    assign led     = led_q;

endmodule

// File: tb/tb_led_pwm_bank.sv
// Scenario bench for led_pwm_bank: expected values are queued when stimulus is driven
// and popped when the corresponding DUT output is sampled on the falling edge.
module tb_led_pwm_bank;

    localparam int NUM_LEDS = 6;
    localparam int AW       = 3;
    localparam int DW       = 10;
    localparam int PERIOD   = 256;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
    logic [AW-1:0]       rd_addr;
    logic [DW-1:0]       rd_data, rd_data_n;
    logic [NUM_LEDS-1:0] led, led_n;

    int checks = 0;
    int errors = 0;
    int n;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    // Edges since the last reset edge; the PWM counter must equal n mod PERIOD.
    always @(posedge clk) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    led_pwm_bank #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(8), .PRESC_BITS(4), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .led(led)
    );

    led_pwm_bank #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(8), .PRESC_BITS(4), .ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_n), .led(led_n)
    );

    // Called at a falling edge; the write lands on the next rising edge and returns one falling edge later.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_mod(input int target, input int after_n);
        int budget = 0;
        while (!(((n % PERIOD) == target) && ((n - after_n) > 1)) && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 1000) begin
            errors++;
            $display("FAIL wait_mod: no alignment to %0d within %0d cycles", target, budget);
        end
    endtask

    // Sample index i holds the pin value produced from pwm_cnt == i.
    task automatic measure(input int idx, output logic [PERIOD-1:0] s);
        for (int i = 0; i < PERIOD; i++) begin
            s[i] = led[idx];
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_write(3'd3, {2'd1, 8'h5A});
        rd_addr = 3'd3;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        sb.push_back('{"rst_led", 32'h00});
        sb.push_back('{"rst_led_active_low", 32'h3F});
        sb.push_back('{"rst_rd_data", 32'h000});
        sb.push_back('{"rst_rd_data_active_low", 32'h000});
        repeat (3) @(negedge clk);
        e = sb.pop_front(); checks++;
        if (32'(led) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, led, e.exp); end
        e = sb.pop_front(); checks++;
        if (32'(led_n) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, led_n, e.exp); end
        e = sb.pop_front(); checks++;
        if (32'(rd_data) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, rd_data, e.exp); end
        e = sb.pop_front(); checks++;
        if (32'(rd_data_n) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, rd_data_n, e.exp); end

        rst = 1'b0;
        sb.push_back('{"post_rst_ch3_cleared", 32'h000});
        sb.push_back('{"post_rst_led_off", 32'h00});
        repeat (2) @(negedge clk);
        e = sb.pop_front(); checks++;
        if (32'(rd_data) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, rd_data, e.exp); end
        e = sb.pop_front(); checks++;
        if (32'(led) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, led, e.exp); end
    endtask

    task automatic test_on_off();
        sb.push_back('{"on_edge_k", 32'h00});
        sb.push_back('{"on_edge_k1", 32'h08});
        sb.push_back('{"on_edge_k1_active_low", 32'h37});
        do_write(3'd3, {2'd1, 8'h00});
        e = sb.pop_front(); checks++;
        if (32'(led) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, led, e.exp); end
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (32'(led) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, led, e.exp); end
        e = sb.pop_front(); checks++;
        if (32'(led_n) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, led_n, e.exp); end

        sb.push_back('{"off_edge_k", 32'h08});
        sb.push_back('{"off_edge_k1", 32'h00});
        do_write(3'd3, {2'd0, 8'hFF});
        e = sb.pop_front(); checks++;
        if (32'(led) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, led, e.exp); end
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (32'(led) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, led, e.exp); end
    endtask

    task automatic test_pwm_duty();
        logic [PERIOD-1:0] s, pat;
        int duties [3];
        int wn;
        duties = '{8'h40, 8'h00, 8'hFF};
        for (int k = 0; k < 3; k++) begin
            do_write(3'd0, {2'd2, 8'(duties[k])});
            wn = n;
            wait_mod(1, wn);
            for (int i = 0; i < PERIOD; i++) pat[i] = (i < duties[k]);
            sb.push_back('{$sformatf("pwm_high_count_duty_%02h", duties[k]), 32'(duties[k])});
            sb.push_back('{$sformatf("pwm_shape_errors_duty_%02h", duties[k]), 32'd0});
            measure(0, s);
            e = sb.pop_front(); checks++;
            if (32'($countones(s)) !== e.exp) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, $countones(s), e.exp); end
            e = sb.pop_front(); checks++;
            if (32'($countones(s ^ pat)) !== e.exp) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, $countones(s ^ pat), e.exp); end
        end
    endtask

    task automatic test_shadow_boundary();
        logic [PERIOD-1:0] s1, s2;
        int wn;
        do_write(3'd1, {2'd2, 8'h80});
        wn = n;
        wait_mod(255, wn);
        sb.push_back('{"shadow_first_period_old_duty", 32'd128});
        sb.push_back('{"shadow_second_period_new_duty", 32'd16});
        do_write(3'd1, {2'd2, 8'h10});
        @(negedge clk);
        measure(1, s1);
        measure(1, s2);
        e = sb.pop_front(); checks++;
        if (32'($countones(s1)) !== e.exp) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, $countones(s1), e.exp); end
        e = sb.pop_front(); checks++;
        if (32'($countones(s2)) !== e.exp) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, $countones(s2), e.exp); end
    endtask

    task automatic test_blink();
        logic [PERIOD-1:0] s, pat;
        int wn;
        do_write(3'd2, {2'd3, 8'h80});
        wn = n;
        wait_mod(1, wn);
        // Blink phase is low for 16 cycles then high for 16, gated by 50 % PWM (cnt < 128).
        for (int i = 0; i < PERIOD; i++) pat[i] = (((i / 16) % 2) == 1) && (i < 128);
        sb.push_back('{"blink_high_count", 32'd64});
        sb.push_back('{"blink_shape_errors", 32'd0});
        measure(2, s);
        e = sb.pop_front(); checks++;
        if (32'($countones(s)) !== e.exp) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, $countones(s), e.exp); end
        e = sb.pop_front(); checks++;
        if (32'($countones(s ^ pat)) !== e.exp) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, $countones(s ^ pat), e.exp); end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{"b2b_ch4_on_ch5_pending", 32'h1});
        sb.push_back('{"b2b_ch4_ch5_on", 32'h3});
        do_write(3'd4, {2'd1, 8'h00});
        do_write(3'd5, {2'd1, 8'h00});
        e = sb.pop_front(); checks++;
        if (32'(led[5:4]) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, led[5:4], e.exp); end
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (32'(led[5:4]) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, led[5:4], e.exp); end

        // Mid-period, ch1 (duty 0x10) is dark; switching it to ON must not wait for the period boundary.
        wait_mod(100, n - 10);
        sb.push_back('{"mode_change_edge_k", 32'h0});
        sb.push_back('{"mode_change_edge_k1", 32'h1});
        do_write(3'd1, {2'd1, 8'h10});
        e = sb.pop_front(); checks++;
        if (32'(led[1]) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, led[1], e.exp); end
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (32'(led[1]) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, led[1], e.exp); end
    endtask

    task automatic test_bounds_readback();
        logic [DW-1:0] exp_rd [8];
        exp_rd = '{10'h2FF, 10'h110, 10'h380, 10'h0FF, 10'h100, 10'h100, 10'h000, 10'h000};
        do_write(3'd7, {2'd1, 8'hAA});
        do_write(3'd6, {2'd1, 8'hBB});
        for (int a = 0; a < 8; a++) begin
            rd_addr = AW'(a);
            sb.push_back('{$sformatf("readback_addr_%0d", a), 32'(exp_rd[a])});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (32'(rd_data) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, rd_data, e.exp); end
        end

        rd_addr = 3'd2;
        sb.push_back('{"read_write_same_edge_old", 32'h380});
        sb.push_back('{"read_after_write_new", 32'h233});
        do_write(3'd2, {2'd2, 8'h33});
        e = sb.pop_front(); checks++;
        if (32'(rd_data) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, rd_data, e.exp); end
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (32'(rd_data) !== e.exp) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, rd_data, e.exp); end
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        test_reset();
        test_on_off();
        test_pwm_duty();
        test_shadow_boundary();
        test_blink();
        test_back_to_back();
        test_bounds_readback();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
